// File: rtl/lstm_pkg.sv
// ============================================================================
// Module  : lstm_pkg
// Brief   : Shared Q8.16 word format, constants and MAC FSM state encoding.
// Revision: 1.0
// ============================================================================
`default_nettype none

package lstm_pkg;

    localparam int WIDTH = 24;
    localparam int FRAC  = 16;

    localparam logic [WIDTH-1:0] ONE  = 24'h010000;
    localparam logic [WIDTH-1:0] MAXV = 24'h7FFFFF;
    localparam logic [WIDTH-1:0] MINV = 24'h800000;

    typedef enum logic [0:0] {
        ACC  = 1'b0,
        HOLD = 1'b1
    } mac_state_e;

endpackage

`default_nettype wire

// File: rtl/sat_q816.sv
// ============================================================================
// Module  : sat_q816
// Brief   : Floor-shift a wide fixed-point value right by FRAC and clamp it
//           to a signed OUT_W-bit word.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sat_q816 #(
    parameter int IN_W  = 52,
    parameter int OUT_W = 24,
    parameter int FRAC  = 16
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout
);

    localparam int               SW    = IN_W - FRAC;
    localparam logic [OUT_W-1:0] C_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] C_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    // Dropping the low bits of a two's-complement value is a floor division.
    logic signed [SW-1:0] sh;
    logic                 unused_frac;

    assign sh          = din[IN_W-1:FRAC];
    assign unused_frac = ^din[FRAC-1:0];

    generate
        if (SW > OUT_W) begin : g_clamp
            logic ovf;
            assign ovf = (sh[SW-1:OUT_W-1] != {(SW-OUT_W+1){sh[SW-1]}});

            always_comb begin
                dout = sh[OUT_W-1:0];
                if (ovf) begin
                    dout = sh[SW-1] ? C_MIN : C_MAX;
                end
            end
        end else begin : g_pass
            assign dout = OUT_W'(sh);
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/gate_mac.sv
// ============================================================================
// Module  : gate_mac
// Brief   : LSTM gate pre-activation MAC: z = sat(bias + sum(w_k * x_k)) in
//           Q8.16, one result per group of N accepted beats.
// Revision: 1.0
// ============================================================================
`default_nettype none

module gate_mac
    import lstm_pkg::*;
#(
    parameter int WIDTH = lstm_pkg::WIDTH,
    parameter int FRAC  = lstm_pkg::FRAC,
    parameter int N     = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_w,
    input  logic signed [WIDTH-1:0] in_x,
    input  logic signed [WIDTH-1:0] in_bias,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic        [WIDTH-1:0] out_z
);

    localparam int CW    = (N > 16) ? $clog2(N) + 1 : 5;
    localparam int ACC_W = 2 * WIDTH + $clog2(N) + 1;

    mac_state_e               state_q,     state_d;
    logic        [CW-1:0]     cnt_q,       cnt_d;
    logic signed [ACC_W-1:0]  acc_q,       acc_d;
    logic        [WIDTH-1:0]  out_z_q,     out_z_d;
    logic                     in_ready_q,  in_ready_d;
    logic                     out_valid_q, out_valid_d;

    logic signed [2*WIDTH-1:0] prod;
    logic signed [ACC_W-1:0]   bias_ext;
    logic signed [ACC_W-1:0]   acc_base;
    logic signed [ACC_W-1:0]   acc_next;
    logic signed [WIDTH-1:0]   sat_z;

    assign prod     = in_w * in_x;
    assign bias_ext = ACC_W'(in_bias) <<< FRAC;
    // The first beat of a group reseeds from the bias, so no explicit clear is needed.
    assign acc_base = (cnt_q == '0) ? bias_ext : acc_q;
    assign acc_next = acc_base + ACC_W'(prod);

    sat_q816 #(
        .IN_W  (ACC_W),
        .OUT_W (WIDTH),
        .FRAC  (FRAC)
    ) u_sat (
        .din  (acc_next),
        .dout (sat_z)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        out_z_d     = out_z_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        case (state_q)
            ACC: begin
                if (in_valid && in_ready_q) begin
                    acc_d = acc_next;
                    if (cnt_q == CW'(N - 1)) begin
                        cnt_d       = '0;
                        state_d     = HOLD;
                        out_z_d     = sat_z;
                        in_ready_d  = 1'b0;
                        out_valid_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d     = ACC;
                    in_ready_d  = 1'b1;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = ACC;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACC;
            cnt_q       <= '0;
            acc_q       <= '0;
            out_z_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            out_z_q     <= out_z_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_z     = out_z_q;

endmodule

`default_nettype wire

// File: tb/tb_gate_mac.sv
// ============================================================================
// Module  : tb_gate_mac
// Brief   : Directed and randomized checks of gate_mac (N=4) against an
//           exact-integer reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_gate_mac;

    localparam int NB = 4;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_w;
    logic [23:0] in_x;
    logic [23:0] in_bias;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_z;

    int tests;
    int fails;

    gate_mac #(
        .WIDTH (24),
        .FRAC  (16),
        .N     (NB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_w      (in_w),
        .in_x      (in_x),
        .in_bias   (in_bias),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_z     (out_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Exact integer sum, floor shift, clamp.
    function automatic logic [23:0] ref_z(input logic [23:0] b,
                                          input logic [23:0] w[NB],
                                          input logic [23:0] x[NB]);
        longint s;
        s = longint'($signed(b)) * 65536;
        for (int k = 0; k < NB; k++) begin
            s = s + longint'($signed(w[k])) * longint'($signed(x[k]));
        end
        s = s >>> 16;
        if (s > 64'sd8388607)  return 24'h7FFFFF;
        if (s < -64'sd8388608) return 24'h800000;
        return s[23:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one beat and return on the negedge after it was accepted.
    task automatic beat(input logic [23:0] w, input logic [23:0] x, input logic [23:0] b);
        int n;
        n = 0;
        in_valid = 1'b0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rdy_wait", in_ready, 1);
        in_w     = w;
        in_x     = x;
        in_bias  = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_w     = 24'($urandom);
        in_x     = 24'($urandom);
        in_bias  = 24'($urandom);
    endtask

    task automatic run_group(input logic [23:0] b,
                             input logic [23:0] w[NB],
                             input logic [23:0] x[NB],
                             input int maxgap,
                             input int hold,
                             input logic hv);
        logic [23:0] exp;
        int          g;
        exp = ref_z(b, w, x);
        for (int k = 0; k < NB; k++) begin
            g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
            repeat (g) begin
                in_valid = 1'b0;
                in_w     = 24'($urandom);
                in_x     = 24'($urandom);
                in_bias  = 24'($urandom);
                @(negedge clk);
            end
            beat(w[k], x[k], (k == 0) ? b : 24'($urandom));
            if (k < NB - 1) chk("ov_early", out_valid, 0);
        end
        chk("ov_set", out_valid, 1);
        chk("z", out_z, exp);
        chk("irdy_hold", in_ready, 0);
        repeat (hold) begin
            in_valid = hv;
            in_w     = 24'($urandom);
            in_x     = 24'($urandom);
            in_bias  = 24'($urandom);
            @(negedge clk);
            chk("z_stable", out_z, exp);
            chk("ov_hold", out_valid, 1);
            chk("irdy_stall", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("ov_clr", out_valid, 0);
        chk("irdy_back", in_ready, 1);
    endtask

    initial begin
        logic [23:0] w[NB];
        logic [23:0] x[NB];
        int          mode;
        logic [23:0] b;

        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_w      = '0;
        in_x      = '0;
        in_bias   = '0;
        out_ready = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_ov", out_valid, 0);
        chk("rst_z", out_z, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_irdy", in_ready, 1);

        // 4 x (1.0 * 0.5) = 2.0
        for (int k = 0; k < NB; k++) begin w[k] = 24'h010000; x[k] = 24'h008000; end
        run_group(24'h000000, w, x, 0, 0, 1'b0);

        // Positive and negative saturation
        for (int k = 0; k < NB; k++) begin w[k] = 24'h7FFFFF; x[k] = 24'h7FFFFF; end
        run_group(24'h7FFFFF, w, x, 0, 0, 1'b0);
        chk("sat_pos_const", out_z, 24'h7FFFFF);
        for (int k = 0; k < NB; k++) begin w[k] = 24'h7FFFFF; x[k] = 24'h800000; end
        run_group(24'h800000, w, x, 0, 0, 1'b0);
        chk("sat_neg_const", out_z, 24'h800000);

        // Floor truncation of tiny products
        for (int k = 0; k < NB; k++) begin w[k] = '0; x[k] = '0; end
        w[0] = 24'hFFFFFF; x[0] = 24'h000001;
        run_group(24'h000000, w, x, 0, 0, 1'b0);
        chk("floor_neg_const", out_z, 24'hFFFFFF);
        w[0] = 24'h000001; x[0] = 24'h000001;
        run_group(24'h000000, w, x, 0, 0, 1'b0);
        chk("floor_pos_const", out_z, 24'h000000);

        // Back-pressure with in_valid held high, then a clean group
        for (int k = 0; k < NB; k++) begin w[k] = 24'h010000 * 24'(k + 1); x[k] = 24'h004000; end
        run_group(24'h000100, w, x, 0, 6, 1'b1);
        for (int k = 0; k < NB; k++) begin w[k] = 24'h020000; x[k] = 24'hFF8000; end
        run_group(24'h030000, w, x, 1, 0, 1'b0);

        // Reset mid-group discards the partial sum
        beat(24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF);
        beat(24'h7FFFFF, 24'h7FFFFF, 24'h000000);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_ov", out_valid, 0);
        chk("mid_rst_z", out_z, 0);
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < NB; k++) begin w[k] = '0; x[k] = '0; end
        run_group(24'h010000, w, x, 0, 0, 1'b0);
        chk("post_rst_const", out_z, 24'h010000);

        // Reset while holding a result drops it
        for (int k = 0; k < NB; k++) begin w[k] = 24'h010000; x[k] = 24'h010000; end
        for (int k = 0; k < NB; k++) beat(w[k], x[k], 24'h000000);
        chk("hold_ov", out_valid, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("hold_rst_ov", out_valid, 0);
        chk("hold_rst_z", out_z, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("hold_rst_irdy", in_ready, 1);

        // Randomized groups with random gaps and random back-pressure
        for (int gidx = 0; gidx < 1000; gidx++) begin
            mode = int'($urandom_range(0, 2));
            for (int k = 0; k < NB; k++) begin
                case (mode)
                    0:       begin w[k] = 24'($urandom); x[k] = 24'($urandom); end
                    1:       begin w[k] = 24'($signed(16'($urandom))); x[k] = 24'($signed(16'($urandom))); end
                    default: begin w[k] = 24'($signed(20'($urandom))); x[k] = 24'($signed(18'($urandom))); end
                endcase
            end
            b = 24'($urandom);
            run_group(b, w, x, 2, int'($urandom_range(0, 2)), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/gate_mac.md
GATE_MAC -- requirements
Module: gate_mac

Interface
REQ-001 SHALL have parameter WIDTH, default 24, meaning signed two's-complement word width, Q8.16 format.
REQ-002 SHALL have parameter FRAC, default 16, meaning number of fractional bits.
REQ-003 SHALL have parameter N, default 8, meaning number of weight/input terms per pre-activation (N >= 1).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port in_valid  input  1  the current beat (in_w, in_x, in_bias) is valid.
REQ-007 SHALL have port in_ready  output  1  the block accepts a beat this cycle.
REQ-008 SHALL have port in_w  input  WIDTH  signed weight, Q8.16.
REQ-009 SHALL have port in_x  input  WIDTH  signed input activation, Q8.16.
REQ-010 SHALL have port in_bias  input  WIDTH  signed bias, Q8.16; sampled only on the first beat of a group.
REQ-011 SHALL have port out_valid  output  1  out_z holds a completed pre-activation.
REQ-012 SHALL have port out_ready  input  1  the downstream sigmoid/tanh stage consumes out_z.
REQ-013 SHALL have port out_z  output  WIDTH  saturated pre-activation z = bias + sum(w_k*x_k), Q8.16.

Function
REQ-014 SHALL implement a two-state FSM, ACC and HOLD.
REQ-015 ACC: in_ready=1 and out_valid=0.
REQ-016 HOLD: in_ready=0 and out_valid=1.
REQ-017 A beat SHALL transfer only when in_valid and in_ready are both 1 on a rising edge.
REQ-018 A 5-bit beat counter cnt SHALL count transferred beats 0..N-1; it sizes to clog2(N)+1 when N>16.
REQ-019 Each product SHALL be the full 2*WIDTH-bit signed product in Q16.32.
REQ-020 The accumulator SHALL be 2*WIDTH+clog2(N)+1 bits, so no internal overflow occurs for any input.
REQ-021 On the beat with cnt==0, the accumulator SHALL load sign-extended (in_bias << FRAC) plus the product.
REQ-022 On each later beat, the accumulator SHALL add the product.
REQ-023 On the beat with cnt==N-1, the FSM SHALL go to HOLD, and cnt SHALL clear to 0.
REQ-024 The out_z register SHALL load sat(acc_next >>> FRAC) on that same edge.
REQ-025 The shift SHALL be arithmetic, truncating toward minus infinity.
REQ-026 Saturation SHALL clamp results above 0x7FFFFF to 0x7FFFFF and results below 0x800000 (signed) to 0x800000.
REQ-027 Latency SHALL be: out_valid asserts on the edge that accepts the Nth beat, and is visible the following cycle.
REQ-028 In HOLD, out_z SHALL remain stable until out_valid && out_ready.
REQ-029 On the edge where out_valid && out_ready, the FSM SHALL return to ACC.
REQ-030 The first beat of the next group SHALL be accepted the cycle after that edge at the earliest, with no overlap of groups.
REQ-031 When in_valid=0 in ACC, accumulator and cnt SHALL hold.
REQ-032 Gaps between beats of a group SHALL be allowed, of any length.
REQ-033 When N==1, each beat SHALL go directly from ACC to HOLD.
REQ-034 in_bias SHALL be ignored on all beats except cnt==0.

Reset
REQ-035 While rst_n=0, the state SHALL be ACC, with cnt=0, accumulator=0, out_z=0, out_valid=0, and in_ready=1 after release.
REQ-036 Reset asserted mid-group or in HOLD SHALL discard the partial sum or pending result; no output SHALL be produced for that group.
REQ-037 Reset deassertion SHALL be synchronised externally; the block SHALL not start a group before the first clk edge after release.

Structure
REQ-038 WIDTH, FRAC, the Q8.16 constants (ONE=0x010000, MAXV=0x7FFFFF, MINV=0x800000), and the FSM state enum SHALL live in shared package lstm_pkg.
REQ-039 Truncate-and-saturate logic SHALL be one combinational sub-module, sat_q816, parameterised by input width; it SHALL be reused by other LSTM stages.
REQ-040 out_z SHALL be driven directly from a register, with no combinational path from in_* to out_*.

Verification
REQ-041 With N=4, bias=0, w=0x010000 and x=0x008000 on all beats -> out_z=0x020000, out_valid one cycle after the 4th beat.
REQ-042 With N=4, bias=0x7FFFFF and w=x=0x7FFFFF on all beats -> out_z=0x7FFFFF. With w=0x7FFFFF, x=0x800000, bias=0x800000 -> out_z=0x800000.
REQ-043 With N=4, bias=0, beat0 w=0xFFFFFF x=0x000001, and other beats w=x=0 -> out_z=0xFFFFFF (floor truncation). With beat0 w=x=0x000001 instead -> out_z=0x000000.
REQ-044 Hold out_ready=0 for 6 cycles after out_valid with in_valid=1 throughout -> out_z stable, in_ready=0, no beat consumed. On release, the next group sums correctly.
REQ-045 Assert rst_n=0 after 2 of 4 beats, then send a fresh 4-beat group (bias=0x010000, w=x=0) -> out_z=0x010000, with no stale contribution.
REQ-046 Random in_valid gaps over 1000 groups, compared against a reference model using exact integer sum, floor shift, and clamp -> bit-exact match.
